counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Command-driven sequencer for the 4-bit up/down/loadable counter datapath. It accepts one command at a time over a valid/ready handshake: load a value, step N times up or down, or run to a target value. It then produces the per-cycle count, direction, wrap and completion indications for the surrounding logic. The block contains the counter register and steps it only under FSM control, so the count holds whenever no command is running.

## Interface
- WIDTH, 4, counter and argument width; step count range is 0..2^WIDTH-1
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; equals (state == IDLE)
- cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 RUN_TO
- cmd_arg  in  WIDTH  load value, step count (UP/DOWN) or target (RUN_TO)
- abort  in  1  terminate a running command
- cnt  out  WIDTH  counter value, registered
- dir  out  1  current direction, 1 = up, registered
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- wrap  out  1  one-cycle pulse, counter crossed max→0 or 0→max

## Operation
- States: IDLE, RUN, DONE.
- Accept: occurs on the rising edge where cmd_valid && cmd_ready. cmd_op and cmd_arg are captured at that edge. cmd_valid is ignored while busy.
- LOAD on accept:
  - cnt <= cmd_arg; dir unchanged.
  - Next state is DONE.
- UP on accept:
  - dir <= 1; remaining <= cmd_arg.
  - If cmd_arg == 0, next state is DONE with cnt unchanged; otherwise next state is RUN.
- DOWN on accept:
  - Same as UP, with dir <= 0.
- RUN_TO on accept:
  - If cmd_arg == cnt, next state is DONE with no step.
  - Otherwise dir <= (cmd_arg > cnt, unsigned) and next state is RUN.
- RUN, each edge:
  - cnt <= cnt ± 1 (modulo 2^WIDTH), per dir.
  - UP/DOWN: remaining decrements; the edge where remaining == 1 moves to DONE.
  - RUN_TO: the edge where the next cnt equals the target moves to DONE. RUN_TO never wraps.
- DONE: lasts exactly one cycle with done = 1, then IDLE.
- abort:
  - Sampled only in RUN. abort = 1 at an edge takes priority over stepping: no step, next state DONE, so done still pulses.
  - Ignored in IDLE and DONE.
- wrap: registered alongside cnt. It is high for the one cycle after an edge where cnt went 2^WIDTH-1 → 0 (up) or 0 → 2^WIDTH-1 (down).
- Reset values: cnt = 0, dir = 1, state IDLE (cmd_ready = 1, busy = 0), done = 0, wrap = 0, remaining = 0.
- rst mid-command: the command is abandoned and no done pulse is produced. rst has priority over every other input.

## Timing
- Accept edge k, LOAD:
  - cnt is the new value from cycle k+1; done is high in cycle k+1.
  - cmd_ready is high again from cycle k+2.
- Accept edge k, UP/DOWN with N ≥ 1:
  - Steps occur at edges k+1..k+N.
  - done is high in cycle k+N+1; cmd_ready returns at k+N+2.
- N = 0 and RUN_TO with cnt already at target: behave like LOAD timing with cnt unchanged.
- RUN_TO with distance D = |target − cnt|: done is high in cycle k+D+1.
- Back-to-back throughput: one command per (latency + 1) cycles. There is no command buffering.
- All outputs are registered or decoded from state only; there are no combinational input→output paths.

## Test plan
- Reset, then LOAD 4'b1010 → cnt = 10 and done = 1 one cycle after accept, cmd_ready high the following cycle, dir = 1.
- cnt = 14, UP 3 → cnt 15, 0, 1 on successive edges; wrap high the cycle cnt = 0; done after the third step.
- cnt = 10, DOWN 5 → dir = 0, cnt 9..5, no wrap, done in cycle k+6.
- cnt = 12, RUN_TO 3 → 9 down-steps to 3, done in cycle k+10. Then RUN_TO 3 → immediate done, cnt stays 3. Then UP 0 → immediate done, cnt unchanged.
- cnt = 0, UP 8, abort asserted at the 4th RUN edge → cnt = 3, done next cycle. cmd_valid held high during busy is not accepted.
- DOWN 6 running, rst asserted for one edge → cnt = 0, dir = 1, no done, cmd_ready = 1. A new LOAD is accepted the next cycle.

Source files
------------

// File: rtl/counter_sequencer.sv
// Command-driven sequencer around a WIDTH-bit up/down/loadable counter.
// Commands: LOAD, step UP/DOWN N times, or RUN_TO a target; abort ends a run early.
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_RUN_TO = 2'b11;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             wrap_reg, wrap_next;
    logic [WIDTH-1:0] remaining_reg, remaining_next;
    logic [WIDTH-1:0] target_reg, target_next;
    logic             run_to_reg, run_to_next;
    logic [WIDTH-1:0] step_val;

    assign step_val = dir_reg ? cnt_reg + WIDTH'(1) : cnt_reg - WIDTH'(1);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        dir_next       = dir_reg;
        wrap_next      = 1'b0;
        remaining_next = remaining_reg;
        target_next    = target_reg;
        run_to_next    = run_to_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            cnt_next   = cmd_arg;
                            state_next = DONE;
                        end
                        OP_UP, OP_DOWN: begin
                            dir_next       = (cmd_op == OP_UP);
                            remaining_next = cmd_arg;
                            run_to_next    = 1'b0;
                            state_next     = (cmd_arg == '0) ? DONE : RUN;
                        end
                        OP_RUN_TO: begin
                            target_next = cmd_arg;
                            run_to_next = 1'b1;
                            if (cmd_arg == cnt_reg) begin
                                state_next = DONE;
                            end else begin
                                dir_next   = (cmd_arg > cnt_reg);
                                state_next = RUN;
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
            RUN: begin
                // abort wins over the step scheduled for this edge
                if (abort) begin
                    state_next = DONE;
                end else begin
                    cnt_next  = step_val;
                    wrap_next = dir_reg ? (cnt_reg == CNT_MAX) : (cnt_reg == '0);
                    if (run_to_reg) begin
                        if (step_val == target_reg) state_next = DONE;
                    end else begin
                        remaining_next = remaining_reg - WIDTH'(1);
                        if (remaining_reg == WIDTH'(1)) state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            dir_reg       <= 1'b1;
            wrap_reg      <= 1'b0;
            remaining_reg <= '0;
            target_reg    <= '0;
            run_to_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dir_reg       <= dir_next;
            wrap_reg      <= wrap_next;
            remaining_reg <= remaining_next;
            target_reg    <= target_next;
            run_to_reg    <= run_to_next;
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign cnt       = cnt_reg;
    assign dir       = dir_reg;
    assign wrap      = wrap_reg;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed test-plan commands, then random ones,
// each checked against an arithmetic model of the command's outcome.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       abort;
    logic [3:0] cnt;
    logic       dir;
    logic       busy;
    logic       done;
    logic       wrap;

    counter_sequencer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .cnt       (cnt),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic       dir;
        int         lat;
        int         wraps;
        int         k;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         wcnt = 0;
    logic [3:0] m_cnt;
    logic       m_dir;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse retires one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (wrap === 1'b1) wcnt++;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("cnt", int'(cnt), int'(e.cnt));
                chk("dir", int'(dir), int'(e.dir));
                chk("latency", cyc - e.k, e.lat);
                chk("wraps", wcnt, e.wraps);
                $display("cmd done at cycle %0d: cnt=%0d dir=%0d lat=%0d wraps=%0d", cyc, cnt, dir, cyc - e.k, wcnt);
            end
            wcnt = 0;
        end
    end

    task automatic junk();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_arg   = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            junk();
            n++;
        end
        if (cmd_ready !== 1'b1) chk("ready_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    // Issue one command at a negedge while idle, model its outcome, follow it to completion.
    task automatic issue(input logic [1:0] op, input logic [3:0] arg, input int abort_j);
        exp_t e;
        int   l;
        int   s;
        int   aj;
        int   n;
        wait_ready();
        l  = 0;
        aj = abort_j;
        case (op)
            2'b00: m_cnt = arg;
            2'b01, 2'b10: begin
                m_dir = (op == 2'b01);
                l     = int'(arg);
            end
            default: begin
                if (arg != m_cnt) begin
                    m_dir = (arg > m_cnt);
                    l     = m_dir ? int'(arg) - int'(m_cnt) : int'(m_cnt) - int'(arg);
                end
            end
        endcase
        if (aj > l) aj = 0;
        s       = (aj > 0) ? aj - 1 : l;
        e.lat   = (aj > 0) ? aj : l;
        e.wraps = m_dir ? (int'(m_cnt) + s) / 16 : (s + 15 - int'(m_cnt)) / 16;
        m_cnt   = m_dir ? m_cnt + 4'(s) : m_cnt - 4'(s);
        e.cnt   = m_cnt;
        e.dir   = m_dir;
        e.k     = cyc + 1;
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        abort     = 1'($urandom_range(0, 1));
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (cmd_ready === 1'b1 || n > 40) break;
            junk();
            abort = (aj != 0 && cyc == e.k + aj - 1) ? 1'b1 :
                    (done === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int aj;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'd0; abort = 1'b0;
        m_cnt = 4'd0; m_dir = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wrap", int'(wrap), 0);
        rst = 1'b0;

        issue(2'b00, 4'd10, 0);
        issue(2'b00, 4'd14, 0);
        issue(2'b01, 4'd3, 0);
        issue(2'b00, 4'd10, 0);
        issue(2'b10, 4'd5, 0);
        issue(2'b00, 4'd12, 0);
        issue(2'b11, 4'd3, 0);
        issue(2'b11, 4'd3, 0);
        issue(2'b01, 4'd0, 0);
        issue(2'b00, 4'd0, 0);
        issue(2'b01, 4'd8, 4);

        // Reset in the middle of DOWN 6: command is dropped with no done pulse
        issue(2'b00, 4'd15, 0);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 4'd6;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cnt", int'(cnt), 0);
        chk("midrst_dir", int'(dir), 1);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_done", int'(done), 0);
        chk("midrst_wrap", int'(wrap), 0);
        m_cnt = 4'd0; m_dir = 1'b1;
        issue(2'b00, 4'd7, 0);

        for (int i = 0; i < 200; i++) begin
            aj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
            issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), aj);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
